// File: rtl/gate_seq_pkg.sv
// Shared types and constants for the gate vector sequencer: FSM states, common
// 2-input truth tables and the vector-count helper.
package gate_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit i is the expected gate output when the input vector equals i.
    localparam logic [3:0] AND2_TT  = 4'b1000;
    localparam logic [3:0] OR2_TT   = 4'b1110;
    localparam logic [3:0] XOR2_TT  = 4'b0110;
    localparam logic [3:0] NAND2_TT = 4'b0111;

    function automatic int NVEC(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_vector_seq_if.sv
// Bundle between the sequencer and the gate under test: stimulus vector out,
// gate response in, plus the sweep status seen by the controlling logic.
interface gate_vector_seq_if #(
    parameter int N_IN = 2
);
    logic            start;
    logic [N_IN-1:0] vec;
    logic            y_in;
    logic            busy;
    logic            done;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] first_err;

    modport master (
        input  start, y_in,
        output vec, busy, done, pass, err_count, first_err
    );

    modport slave (
        output start, y_in,
        input  vec, busy, done, pass, err_count, first_err
    );
endinterface

// File: rtl/gate_seq_hold_cnt.sv
// Modulo-HOLD_CYCLES counter; 'last' is high while the count sits on its final
// value, so an enabled edge with 'last' set wraps the count back to zero.
module gate_seq_hold_cnt #(
    parameter int HOLD_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);
    localparam int             CW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= last ? '0 : r_cnt + 1'b1;
        end
    end

    assign last = (r_cnt == CNT_MAX);
endmodule

// File: rtl/gate_vector_seq.sv
// On-chip gate self-test: sweeps all 2**N_IN vectors, each held HOLD_CYCLES clocks,
// and checks y_in against EXPECT_TT. GATE_SEQ_HALT_ON_ERR_EN stops on the first mismatch.
module gate_vector_seq
    import gate_seq_pkg::*;
#(
    parameter int                      N_IN        = 2,
    parameter int                      HOLD_CYCLES = 10,
    parameter logic [NVEC(N_IN)-1:0]   EXPECT_TT   = AND2_TT
) (
    input  logic               clk,
    input  logic               rst,
    gate_vector_seq_if.master  bus
);
    localparam int              NV       = NVEC(N_IN);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);
    localparam logic [N_IN:0]   ERR_SAT  = (N_IN + 1)'(NV);

    state_t          r_state, w_state_nxt;
    logic [N_IN-1:0] r_vec, w_vec_nxt;
    logic [N_IN-1:0] r_first_err, w_first_err_nxt;
    logic [N_IN:0]   r_err, w_err_nxt;
    logic            w_last, w_clr, w_en, w_mis;

    assign w_en  = (r_state == RUN);
    assign w_mis = (bus.y_in != EXPECT_TT[r_vec]);

    gate_seq_hold_cnt #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .last (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_err       <= '0;
            r_first_err <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_vec       <= w_vec_nxt;
            r_err       <= w_err_nxt;
            r_first_err <= w_first_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_vec_nxt       = r_vec;
        w_err_nxt       = r_err;
        w_first_err_nxt = r_first_err;
        w_clr           = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt     = RUN;
                    w_vec_nxt       = '0;
                    w_err_nxt       = '0;
                    w_first_err_nxt = '0;
                    w_clr           = 1'b1;
                end
            end
            RUN: begin
                if (w_last) begin
                    if (w_mis) begin
                        w_err_nxt = (r_err == ERR_SAT) ? r_err : r_err + 1'b1;
                        if (r_err == '0) begin
                            w_first_err_nxt = r_vec;
                        end
                    end
`ifdef GATE_SEQ_HALT_ON_ERR_EN
                    if (w_mis || (r_vec == LAST_VEC)) begin
`else
                    if (r_vec == LAST_VEC) begin
`endif
                        w_state_nxt = DONE;
                    end else begin
                        w_vec_nxt = r_vec + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status flags decode straight from the state so busy/done can never overlap.
    assign bus.vec       = r_vec;
    assign bus.busy      = (r_state == RUN);
    assign bus.done      = (r_state == DONE);
    assign bus.pass      = (r_state == DONE) && (r_err == '0);
    assign bus.err_count = r_err;
    assign bus.first_err = r_first_err;
endmodule
